// File: rtl/lc3b_types.sv
// Shared LC-3b predictor types: BHT history, PHT index/counter types, counter constants and the PHT index hash.
// PHT_GSHARE_EN selects the XOR (gshare) index instead of the {pc, hist} concatenation.
package lc3b_types;

    localparam int PHT_HIST_W = 4;
    localparam int PHT_IDX_W  = 6;

    typedef logic [PHT_HIST_W-1:0] lc3b_bht_out;
    typedef logic [PHT_IDX_W-1:0]  lc3b_pht_ind;
    typedef logic [1:0]            lc3b_pht_ctr;

    localparam lc3b_pht_ctr PHT_SNT      = 2'b00;
    localparam lc3b_pht_ctr PHT_WNT      = 2'b01;
    localparam lc3b_pht_ctr PHT_WT       = 2'b10;
    localparam lc3b_pht_ctr PHT_ST       = 2'b11;
    localparam lc3b_pht_ctr PHT_INIT_VAL = PHT_WNT;

    typedef enum logic [0:0] {
        PHT_ST_INIT = 1'b0,
        PHT_ST_RUN  = 1'b1
    } pht_state_e;

    // Low PC bits above the history, or all PC bits XORed with the zero-extended history.
    function automatic lc3b_pht_ind pht_index(input lc3b_pht_ind pc, input lc3b_bht_out hist);
`ifdef PHT_GSHARE_EN
        pht_index = pc ^ {{(PHT_IDX_W-PHT_HIST_W){1'b0}}, hist};
`else
        pht_index = lc3b_pht_ind'({pc, hist});
`endif
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next value of a 2-bit saturating branch counter.
module sat_counter2
    import lc3b_types::*;
(
    input  lc3b_pht_ctr ctr,
    input  logic        taken,
    output lc3b_pht_ctr nxt
);

    // Step toward strong-taken or strong-not-taken, holding at either end.
    always_comb begin
        nxt = ctr;
        case (ctr)
            PHT_SNT: nxt = taken ? PHT_WNT : PHT_SNT;
            PHT_WNT: nxt = taken ? PHT_WT  : PHT_SNT;
            PHT_WT:  nxt = taken ? PHT_ST  : PHT_WNT;
            PHT_ST:  nxt = taken ? PHT_ST  : PHT_WT;
            default: nxt = ctr;
        endcase
    end

endmodule

// File: rtl/pattern_history_table.sv
// Pattern history table: 2-bit counter array with registered prediction, 2-stage update RMW and forwarding.
// Index hash follows PHT_GSHARE_EN (see lc3b_types).
module pattern_history_table
    import lc3b_types::*;
#(
    parameter int HIST_W = PHT_HIST_W,
    parameter int IDX_W  = PHT_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              pred_valid,
    input  logic [IDX_W-1:0]  pred_pc,
    input  logic [HIST_W-1:0] pred_hist,
    output logic              pred_out_valid,
    output logic              pred_taken,
    output logic [1:0]        pred_ctr,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken
);

    localparam int DEPTH = 1 << IDX_W;

    pht_state_e       state_r;
    logic [IDX_W-1:0] init_idx_r;
    logic             ready_r;
    lc3b_pht_ctr      mem_r [DEPTH];

    logic             run_s;
    logic [IDX_W-1:0] pred_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    lc3b_pht_ctr      pred_rd_s;
    lc3b_pht_ctr      u1_rd_s;
    lc3b_pht_ctr      u2_new_s;

    logic             u1_valid_r;
    logic [IDX_W-1:0] u1_idx_r;
    logic             u1_taken_r;
    logic             u2_valid_r;
    logic [IDX_W-1:0] u2_idx_r;
    logic             u2_taken_r;
    lc3b_pht_ctr      u2_ctr_r;

    logic             pred_out_valid_r;
    logic             pred_taken_r;
    lc3b_pht_ctr      pred_ctr_r;

    assign run_s      = (state_r == PHT_ST_RUN);
    assign pred_idx_s = pht_index(pred_pc, pred_hist);
    assign upd_idx_s  = pht_index(upd_pc, upd_hist);

    sat_counter2 u_sat (
        .ctr   (u2_ctr_r),
        .taken (u2_taken_r),
        .nxt   (u2_new_s)
    );

    // Read muxes with write-first bypass from the U2 write port.
    always_comb begin
        pred_rd_s = mem_r[pred_idx_s];
        u1_rd_s   = mem_r[u1_idx_r];
        if (u2_valid_r && (u2_idx_r == pred_idx_s)) begin
            pred_rd_s = u2_new_s;
        end else begin
            pred_rd_s = mem_r[pred_idx_s];
        end
        if (u2_valid_r && (u2_idx_r == u1_idx_r)) begin
            u1_rd_s = u2_new_s;
        end else begin
            u1_rd_s = mem_r[u1_idx_r];
        end
    end

    // Init walk FSM: one weakly-not-taken write per cycle, then RUN until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= PHT_ST_INIT;
            init_idx_r <= {IDX_W{1'b0}};
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                PHT_ST_INIT: begin
                    if (init_idx_r == {IDX_W{1'b1}}) begin
                        state_r <= PHT_ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        init_idx_r <= init_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                PHT_ST_RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= PHT_ST_INIT;
                    init_idx_r <= {IDX_W{1'b0}};
                    ready_r    <= 1'b0;
                end
            endcase
        end
    end

    // Counter array write port; contents are not reset because the walk rewrites them.
    always_ff @(posedge clk) begin
        if (state_r == PHT_ST_INIT) begin
            mem_r[init_idx_r] <= PHT_INIT_VAL;
        end else if (u2_valid_r) begin
            mem_r[u2_idx_r] <= u2_new_s;
        end
    end

    // Update pipeline: U1 captures the request, U2 holds the forwarded read for the saturating write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u1_valid_r <= 1'b0;
            u1_idx_r   <= {IDX_W{1'b0}};
            u1_taken_r <= 1'b0;
            u2_valid_r <= 1'b0;
            u2_idx_r   <= {IDX_W{1'b0}};
            u2_taken_r <= 1'b0;
            u2_ctr_r   <= PHT_SNT;
        end else begin
            u1_valid_r <= upd_valid && run_s;
            u1_idx_r   <= upd_idx_s;
            u1_taken_r <= upd_taken;
            u2_valid_r <= u1_valid_r;
            u2_idx_r   <= u1_idx_r;
            u2_taken_r <= u1_taken_r;
            u2_ctr_r   <= u1_rd_s;
        end
    end

    // Registered prediction result; requests during the walk are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_out_valid_r <= 1'b0;
            pred_taken_r     <= 1'b0;
            pred_ctr_r       <= PHT_SNT;
        end else if (pred_valid && run_s) begin
            pred_out_valid_r <= 1'b1;
            pred_taken_r     <= pred_rd_s[1];
            pred_ctr_r       <= pred_rd_s;
        end else begin
            pred_out_valid_r <= 1'b0;
        end
    end

    assign ready          = ready_r;
    assign pred_out_valid = pred_out_valid_r;
    assign pred_taken     = pred_taken_r;
    assign pred_ctr       = pred_ctr_r;

endmodule

// File: tb/tb_pattern_history_table.sv
// Self-checking bench for pattern_history_table against a time-based counter-array model.
module tb_pattern_history_table;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready;
    logic       pred_valid = 1'b0;
    logic [5:0] pred_pc = 6'd0;
    logic [3:0] pred_hist = 4'd0;
    logic       pred_out_valid;
    logic       pred_taken;
    logic [1:0] pred_ctr;
    logic       upd_valid = 1'b0;
    logic [5:0] upd_pc = 6'd0;
    logic [3:0] upd_hist = 4'd0;
    logic       upd_taken = 1'b0;

    always #5 clk = ~clk;

    pattern_history_table dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_hist      (pred_hist),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_ctr       (pred_ctr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_hist       (upd_hist),
        .upd_taken      (upd_taken)
    );

    typedef struct {
        int t;
        int idx;
        int tk;
    } pend_t;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    model [64];
    pend_t pend [$];
    int    cyc = 0;
    int    edges = 0;

    function automatic int idx_of(input int pc, input int hist);
`ifdef PHT_GSHARE_EN
        return (pc ^ hist) % 64;
`else
        return (pc % 4) * 16 + hist;
`endif
    endfunction

    function automatic int pc_of(input int idx);
`ifdef PHT_GSHARE_EN
        return idx;
`else
        return idx / 16;
`endif
    endfunction

    function automatic int hist_of(input int idx);
`ifdef PHT_GSHARE_EN
        return 0;
`else
        return idx % 16;
`endif
    endfunction

    function automatic int sat(input int c, input int tk);
        if (tk != 0) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // An update issued in cycle t becomes visible to predictions in cycle t+2 and later.
    task automatic apply_due();
        pend_t p;
        while (pend.size() > 0 && pend[0].t <= cyc - 2) begin
            p = pend.pop_front();
            model[p.idx] = sat(model[p.idx], p.tk);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 1;
        pend.delete();
    endtask

    task automatic tick(input int pv, input int ppc, input int phist,
                        input int uv, input int upc, input int uhist, input int ut);
        int rdy;
        int exp_v;
        int exp_ctr;
        rdy = (edges >= 64) ? 1 : 0;
        pred_valid = (pv != 0);
        pred_pc    = ppc[5:0];
        pred_hist  = phist[3:0];
        upd_valid  = (uv != 0);
        upd_pc     = upc[5:0];
        upd_hist   = uhist[3:0];
        upd_taken  = (ut != 0);
        exp_v   = (pv != 0 && rdy != 0) ? 1 : 0;
        exp_ctr = 0;
        if (exp_v != 0) begin
            apply_due();
            exp_ctr = model[idx_of(ppc, phist)];
        end
        if (uv != 0 && rdy != 0) pend.push_back('{cyc, idx_of(upc, uhist), ut});
        @(posedge clk);
        #1;
        edges++;
        cyc++;
        check("ready", 32'(ready), (edges >= 64) ? 32'd1 : 32'd0);
        check("pred_out_valid", 32'(pred_out_valid), 32'(exp_v));
        if (exp_v != 0) begin
            check("pred_ctr", 32'(pred_ctr), 32'(exp_ctr));
            check("pred_taken", 32'(pred_taken), 32'(exp_ctr / 2));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic predict(input int pc, input int hist);
        tick(1, pc, hist, 0, 0, 0, 0);
    endtask

    task automatic update(input int pc, input int hist, input int tk);
        tick(0, 0, 0, 1, pc, hist, tk);
    endtask

    // Asserts reset mid-cycle, checks outputs drop at once, then releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_pred_out_valid", 32'(pred_out_valid), 32'd0);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_pred_ctr", 32'(pred_ctr), 32'd0);
        model_reset();
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Init walk: requests at cycles 10 and 20 are dropped.
        for (int i = 0; i < 64; i++) tick((i == 9) ? 1 : 0, 5, 3, (i == 19) ? 1 : 0, 5, 3, 1);

        predict(5, 3);
        for (int i = 0; i < 4; i++) predict($urandom_range(0, 63), $urandom_range(0, 15));

        // Bypass timing on index 0x13.
        update(5, 3, 1);
        predict(5, 3);
        predict(5, 3);
        predict(5, 3);

        // Prediction and update in the same cycle: pre-update value.
        tick(1, 5, 3, 1, 5, 3, 0);
        idle(2);
        predict(5, 3);

        // Saturation at both ends with back-to-back updates.
        for (int i = 0; i < 3; i++) update(5, 3, 1);
        idle(2);
        predict(5, 3);
        for (int i = 0; i < 2; i++) update(5, 3, 1);
        idle(2);
        predict(5, 3);
        for (int i = 0; i < 4; i++) update(5, 3, 0);
        idle(2);
        predict(5, 3);

        // Alternating outcomes on a fresh entry return it to weakly-not-taken.
        for (int i = 0; i < 6; i++) update(2, 7, (i % 2 == 0) ? 1 : 0);
        idle(2);
        predict(2, 7);

        // Index hash: pc=0x0A, hist=3 lands on 0x09 (gshare) or 0x23 (concatenation).
        update(10, 3, 1);
        update(10, 3, 1);
        idle(2);
        predict(pc_of(9), hist_of(9));
        predict(pc_of(35), hist_of(35));

        // Random traffic over a small index set to provoke collisions and forwarding.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 1));
        end

        // Reset in the middle of an update burst.
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 0, 0, 1);
        do_reset();
        idle(64);
        for (int i = 0; i < 64; i++) predict(pc_of(i), hist_of(i));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
